// File: rtl/jtkicker_objscan.sv
// Object table line scanner: walks the object RAM once per video line,
// finds the objects that cross the line being prepared and hands them one
// at a time to the object draw unit over a draw/busy handshake.
module jtkicker_objscan #(
    parameter int          NOBJ     = 24,
    parameter int          LINE_MAX = 16,
    parameter logic [7:0]  YOFFSET  = 8'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen2,
    input  logic       hinit_x,
    input  logic [7:0] vrender,
    input  logic       flip,
    output logic [7:0] obj_addr,
    input  logic [7:0] obj_dout,
    output logic       draw,
    input  logic       busy,
    output logic [7:0] xpos,
    output logic [3:0] ysub,
    output logic [3:0] pal,
    output logic       hflip,
    output logic       vflip,
    output logic [8:0] code,
    output logic       done,
    output logic       ovf
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CHECK,
        DRAW,
        DONE
    } state_t;

    // Byte offsets inside one 4-byte object entry
    localparam logic [1:0] B_ATTR = 2'd0;
    localparam logic [1:0] B_CODE = 2'd1;
    localparam logic [1:0] B_Y    = 2'd2;
    localparam logic [1:0] B_X    = 2'd3;

    localparam logic [5:0] LAST_IDX = 6'(NOBJ - 1);
    localparam logic [6:0] LMAX     = 7'(LINE_MAX);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [5:0]  idx_q, idx_d;
    logic [6:0]  hits_q, hits_d;

    logic        entVflip_q, entVflip_d;
    logic        entHflip_q, entHflip_d;
    logic [8:0]  entCode_q, entCode_d;
    logic [3:0]  entPal_q, entPal_d;
    logic [7:0]  entY_q, entY_d;
    logic [7:0]  entX_q, entX_d;

    logic [7:0]  objAddr_q, objAddr_d;
    logic        draw_q, draw_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  xpos_q, xpos_d;
    logic [3:0]  ysub_q, ysub_d;
    logic [3:0]  pal_q, pal_d;
    logic        hflip_q, hflip_d;
    logic        vflip_q, vflip_d;
    logic [8:0]  code_q, code_d;

    logic [7:0]  yDiff;
    logic        isHit;
    logic [5:0]  nextIdx;
    logic        lastObj;

    // Line match: distance from the object top to the line, wrapping at 256
    always_comb begin
        yDiff   = (vrender ^ {8{flip}}) - (entY_q + YOFFSET);
        isHit   = (yDiff < 8'd16);
        nextIdx = idx_q + 6'd1;
        lastObj = (idx_q == LAST_IDX);
    end

    // Next-state logic. Byte0 of the following entry is addressed while the
    // current entry's last byte is still in flight, so leaving CHECK or DRAW
    // jumps straight to the second fetch step and a missed object costs
    // exactly five cen2 cycles.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        hits_d     = hits_q;
        entVflip_d = entVflip_q;
        entHflip_d = entHflip_q;
        entCode_d  = entCode_q;
        entPal_d   = entPal_q;
        entY_d     = entY_q;
        entX_d     = entX_q;
        objAddr_d  = objAddr_q;
        draw_d     = draw_q;
        done_d     = done_q;
        ovf_d      = ovf_q;
        xpos_d     = xpos_q;
        ysub_d     = ysub_q;
        pal_d      = pal_q;
        hflip_d    = hflip_q;
        vflip_d    = vflip_q;
        code_d     = code_q;

        if (hinit_x) begin
            state_d   = FETCH;
            cnt_d     = 3'd0;
            idx_d     = 6'd0;
            hits_d    = 7'd0;
            done_d    = 1'b0;
            ovf_d     = 1'b0;
            draw_d    = 1'b0;
            objAddr_d = {6'd0, B_ATTR};
        end else begin
            case (state_q)
                IDLE: begin
                end

                FETCH: begin
                    case (cnt_q)
                        3'd1: begin
                            entVflip_d     = obj_dout[7];
                            entHflip_d     = obj_dout[6];
                            entCode_d[8]   = obj_dout[4];
                            entPal_d       = obj_dout[3:0];
                        end
                        3'd2:    entCode_d[7:0] = obj_dout;
                        3'd3:    entY_d         = obj_dout;
                        3'd4:    entX_d         = obj_dout;
                        default: begin
                        end
                    endcase
                    case (cnt_q)
                        3'd0:    objAddr_d = {idx_q, B_CODE};
                        3'd1:    objAddr_d = {idx_q, B_Y};
                        3'd2:    objAddr_d = {idx_q, B_X};
                        3'd3:    objAddr_d = {nextIdx, B_ATTR};
                        default: begin
                        end
                    endcase
                    if (cnt_q == 3'd4) begin
                        state_d = CHECK;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end

                CHECK: begin
                    if (isHit) begin
                        ysub_d  = yDiff[3:0];
                        pal_d   = entPal_q;
                        code_d  = entCode_q;
                        hflip_d = entHflip_q ^ flip;
                        vflip_d = entVflip_q ^ flip;
                        xpos_d  = flip ? (8'd240 - entX_q) : entX_q;
                        draw_d  = 1'b1;
                        state_d = DRAW;
                    end else begin
                        idx_d = nextIdx;
                        if (lastObj) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            cnt_d     = 3'd1;
                            objAddr_d = {nextIdx, B_CODE};
                            state_d   = FETCH;
                        end
                    end
                end

                DRAW: begin
                    if (!busy) begin
                        draw_d = 1'b0;
                        hits_d = hits_q + 7'd1;
                        idx_d  = nextIdx;
                        if (hits_q + 7'd1 == LMAX) begin
                            ovf_d   = 1'b1;
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else if (lastObj) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            cnt_d     = 3'd1;
                            objAddr_d = {nextIdx, B_CODE};
                            state_d   = FETCH;
                        end
                    end
                end

                DONE: begin
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers, advancing only on cen2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            idx_q      <= 6'd0;
            hits_q     <= 7'd0;
            entVflip_q <= 1'b0;
            entHflip_q <= 1'b0;
            entCode_q  <= 9'd0;
            entPal_q   <= 4'd0;
            entY_q     <= 8'd0;
            entX_q     <= 8'd0;
            objAddr_q  <= 8'd0;
            draw_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            xpos_q     <= 8'd0;
            ysub_q     <= 4'd0;
            pal_q      <= 4'd0;
            hflip_q    <= 1'b0;
            vflip_q    <= 1'b0;
            code_q     <= 9'd0;
        end else if (cen2) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            hits_q     <= hits_d;
            entVflip_q <= entVflip_d;
            entHflip_q <= entHflip_d;
            entCode_q  <= entCode_d;
            entPal_q   <= entPal_d;
            entY_q     <= entY_d;
            entX_q     <= entX_d;
            objAddr_q  <= objAddr_d;
            draw_q     <= draw_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            xpos_q     <= xpos_d;
            ysub_q     <= ysub_d;
            pal_q      <= pal_d;
            hflip_q    <= hflip_d;
            vflip_q    <= vflip_d;
            code_q     <= code_d;
        end
    end

    assign obj_addr = objAddr_q;
    assign draw     = draw_q;
    assign done     = done_q;
    assign ovf      = ovf_q;
    assign xpos     = xpos_q;
    assign ysub     = ysub_q;
    assign pal      = pal_q;
    assign hflip    = hflip_q;
    assign vflip    = vflip_q;
    assign code     = code_q;

endmodule

// File: tb/tb_jtkicker_objscan.sv
// Directed bench for the object line scanner with a registered object RAM.
module tb_jtkicker_objscan;

    logic       clk = 1'b0;
    logic       rst;
    logic       cen2 = 1'b0;
    logic       hinit_x;
    logic [7:0] vrender;
    logic       flip;
    logic [7:0] obj_addr;
    logic [7:0] obj_dout = 8'd0;
    logic       draw;
    logic       busy;
    logic [7:0] xpos;
    logic [3:0] ysub;
    logic [3:0] pal;
    logic       hflip;
    logic       vflip;
    logic [8:0] code;
    logic       done;
    logic       ovf;

    logic [7:0] mem [0:255];
    int errors = 0;
    int checks = 0;

    jtkicker_objscan dut (
        .clk      (clk),
        .rst      (rst),
        .cen2     (cen2),
        .hinit_x  (hinit_x),
        .vrender  (vrender),
        .flip     (flip),
        .obj_addr (obj_addr),
        .obj_dout (obj_dout),
        .draw     (draw),
        .busy     (busy),
        .xpos     (xpos),
        .ysub     (ysub),
        .pal      (pal),
        .hflip    (hflip),
        .vflip    (vflip),
        .code     (code),
        .done     (done),
        .ovf      (ovf)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // cen2 active on every other rising edge, changed away from it
    always @(negedge clk) cen2 = ~cen2;

    // Object RAM with one cen2 cycle of read latency
    always @(posedge clk) if (cen2) obj_dout <= mem[obj_addr];

    task automatic stepCen();
        do @(posedge clk); while (cen2 !== 1'b1);
        #1;
    endtask

    task automatic setObj(input int i, input logic [7:0] a, input logic [7:0] c,
                          input logic [7:0] y, input logic [7:0] x);
        mem[4*i+0] = a;
        mem[4*i+1] = c;
        mem[4*i+2] = y;
        mem[4*i+3] = x;
    endtask

    task automatic clearObjs(input logic [7:0] fillY);
        for (int i = 0; i < 64; i++) setObj(i, 8'h00, 8'h00, fillY, 8'h00);
    endtask

    task automatic applyStimulus(input logic [7:0] vr, input logic fl);
        vrender = vr;
        flip    = fl;
        hinit_x = 1'b1;
        stepCen();
        hinit_x = 1'b0;
    endtask

    task automatic waitDraw(input int maxSteps, output int steps, output bit seen);
        seen  = 1'b0;
        steps = 0;
        while (!seen && steps < maxSteps) begin
            stepCen();
            steps++;
            if (draw === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic runToDone(input int maxSteps, output int draws, output int steps,
                             output bit seen);
        draws = 0;
        steps = 0;
        seen  = 1'b0;
        while (!seen && steps < maxSteps) begin
            stepCen();
            steps++;
            if (draw === 1'b1) draws++;
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; hinit_x = 1'b0; busy = 1'b0; flip = 1'b0; vrender = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({obj_addr, draw, done, ovf, xpos, ysub, pal, code, hflip, vflip} !== 43'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {obj_addr, draw, done, ovf, xpos, ysub, pal, code, hflip, vflip});
        end
        rst = 1'b0;
        repeat (10) stepCen();
        checks++;
        if ({obj_addr, draw, done} !== 10'd0) begin
            errors++;
            $display("[TB] FAIL no_start_after_reset: got %h expected 0", {obj_addr, draw, done});
        end
    endtask

    task automatic test_no_hits();
        int d, s;
        bit fin;
        clearObjs(8'h00);
        applyStimulus(8'h80, 1'b0);
        checks++;
        if (obj_addr !== 8'h00) begin
            errors++; $display("[TB] FAIL addr_step0: got %h expected 00", obj_addr);
        end
        for (int k = 1; k <= 4; k++) begin
            stepCen();
            checks++;
            if (obj_addr !== 8'(k)) begin
                errors++; $display("[TB] FAIL addr_step%0d: got %h expected %h", k, obj_addr, 8'(k));
            end
        end
        runToDone(300, d, s, fin);
        checks++;
        if (!fin || s + 4 != 121) begin
            errors++; $display("[TB] FAIL nohit_done_time: got %0d expected 121 (seen %0d)", s + 4, fin);
        end
        checks++;
        if (d != 0 || ovf !== 1'b0) begin
            errors++; $display("[TB] FAIL nohit_draws: got draws=%0d ovf=%b expected 0 0", d, ovf);
        end
    endtask

    task automatic test_single_hit();
        int s, d, s2;
        bit seen, fin;
        clearObjs(8'h00);
        setObj(0, 8'h13, 8'h05, 8'h40, 8'h20);
        busy = 1'b0;
        applyStimulus(8'h45, 1'b0);
        waitDraw(20, s, seen);
        checks++;
        if (!seen || s != 6) begin
            errors++; $display("[TB] FAIL hit_latency: got %0d expected 6 (seen %0d)", s, seen);
        end
        checks++;
        if ({xpos, ysub, pal, code, hflip, vflip} !== {8'h20, 4'd5, 4'd3, 9'h105, 1'b0, 1'b0}) begin
            errors++; $display("[TB] FAIL hit_fields: got %h expected %h",
                               {xpos, ysub, pal, code, hflip, vflip},
                               {8'h20, 4'd5, 4'd3, 9'h105, 1'b0, 1'b0});
        end
        runToDone(300, d, s2, fin);
        checks++;
        if (d != 0 || !fin || s + s2 != 122) begin
            errors++; $display("[TB] FAIL hit_done: got extra=%0d time=%0d expected 0 122", d, s + s2);
        end
    endtask

    task automatic test_wrap();
        int s, d, s2;
        bit seen, fin;
        clearObjs(8'h80);
        setObj(0, 8'h00, 8'h77, 8'hF8, 8'h10);
        applyStimulus(8'h03, 1'b0);
        waitDraw(20, s, seen);
        checks++;
        if (!seen || s != 6 || {ysub, code, xpos} !== {4'd11, 9'h077, 8'h10}) begin
            errors++; $display("[TB] FAIL wrap_hit: got s=%0d %h expected s=6 %h", s,
                               {ysub, code, xpos}, {4'd11, 9'h077, 8'h10});
        end
        runToDone(300, d, s2, fin);
        checks++;
        if (d != 0 || !fin) begin
            errors++; $display("[TB] FAIL wrap_rest: got draws=%0d done=%0d expected 0 1", d, fin);
        end
        clearObjs(8'h00);
        setObj(0, 8'h00, 8'h11, 8'h40, 8'h50);
        setObj(1, 8'h10, 8'h12, 8'h41, 8'h30);
        applyStimulus(8'h50, 1'b0);
        waitDraw(30, s, seen);
        checks++;
        if (!seen || s != 11 || {ysub, code, xpos} !== {4'd15, 9'h112, 8'h30}) begin
            errors++; $display("[TB] FAIL boundary_hit: got s=%0d %h expected s=11 %h", s,
                               {ysub, code, xpos}, {4'd15, 9'h112, 8'h30});
        end
        runToDone(300, d, s2, fin);
        checks++;
        if (d != 0 || !fin) begin
            errors++; $display("[TB] FAIL boundary_rest: got draws=%0d done=%0d expected 0 1", d, fin);
        end
    endtask

    task automatic test_busy_hold();
        int s, d, s2, bad;
        bit seen, fin;
        clearObjs(8'h00);
        setObj(0, 8'h13, 8'h05, 8'h40, 8'h20);
        busy = 1'b1;
        applyStimulus(8'h45, 1'b0);
        waitDraw(20, s, seen);
        checks++;
        if (!seen || s != 6) begin
            errors++; $display("[TB] FAIL busy_first_draw: got %0d expected 6", s);
        end
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            stepCen();
            if (draw !== 1'b1 ||
                {xpos, ysub, pal, code, hflip, vflip} !== {8'h20, 4'd5, 4'd3, 9'h105, 1'b0, 1'b0})
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("[TB] FAIL busy_hold: got %0d unstable cycles expected 0", bad);
        end
        busy = 1'b0;
        stepCen();
        checks++;
        if (draw !== 1'b0) begin
            errors++; $display("[TB] FAIL busy_accept: got draw=%b expected 0", draw);
        end
        runToDone(300, d, s2, fin);
        checks++;
        if (d != 0 || !fin) begin
            errors++; $display("[TB] FAIL busy_single: got extra=%0d done=%0d expected 0 1", d, fin);
        end
    endtask

    task automatic test_overflow();
        int d, s;
        bit fin;
        clearObjs(8'h00);
        for (int i = 0; i < 24; i++) setObj(i, 8'h01, 8'(i), 8'h40, 8'(i));
        busy = 1'b0;
        applyStimulus(8'h45, 1'b0);
        runToDone(400, d, s, fin);
        checks++;
        if (!fin || d != 16 || s != 97 || ovf !== 1'b1) begin
            errors++; $display("[TB] FAIL overflow: got draws=%0d time=%0d ovf=%b expected 16 97 1",
                               d, s, ovf);
        end
        repeat (10) stepCen();
        checks++;
        if ({done, ovf, draw} !== 3'b110) begin
            errors++; $display("[TB] FAIL done_hold: got %b expected 110", {done, ovf, draw});
        end
        clearObjs(8'h00);
        applyStimulus(8'h45, 1'b0);
        checks++;
        if ({done, ovf} !== 2'b00) begin
            errors++; $display("[TB] FAIL hinit_clear: got %b expected 00", {done, ovf});
        end
        runToDone(300, d, s, fin);
    endtask

    task automatic test_flip();
        int s, d, s2;
        bit seen, fin;
        clearObjs(8'h00);
        setObj(0, 8'h02, 8'h10, 8'hB0, 8'h20);
        setObj(1, 8'hC5, 8'h33, 8'hB2, 8'h00);
        applyStimulus(8'h45, 1'b1);
        waitDraw(20, s, seen);
        checks++;
        if (!seen || {xpos, ysub, pal, code, hflip, vflip} !==
                     {8'hD0, 4'd10, 4'd2, 9'h010, 1'b1, 1'b1}) begin
            errors++; $display("[TB] FAIL flip_obj0: got %h expected %h",
                               {xpos, ysub, pal, code, hflip, vflip},
                               {8'hD0, 4'd10, 4'd2, 9'h010, 1'b1, 1'b1});
        end
        waitDraw(20, s, seen);
        checks++;
        if (!seen || {xpos, ysub, pal, code, hflip, vflip} !==
                     {8'hF0, 4'd8, 4'd5, 9'h033, 1'b0, 1'b0}) begin
            errors++; $display("[TB] FAIL flip_obj1: got %h expected %h",
                               {xpos, ysub, pal, code, hflip, vflip},
                               {8'hF0, 4'd8, 4'd5, 9'h033, 1'b0, 1'b0});
        end
        runToDone(300, d, s2, fin);
        checks++;
        if (d != 0 || !fin) begin
            errors++; $display("[TB] FAIL flip_rest: got draws=%0d done=%0d expected 0 1", d, fin);
        end
        flip = 1'b0;
    endtask

    task automatic test_restart();
        int s, d, s2;
        bit seen, fin;
        clearObjs(8'h00);
        setObj(0, 8'h13, 8'h05, 8'h40, 8'h20);
        busy = 1'b1;
        applyStimulus(8'h45, 1'b0);
        waitDraw(20, s, seen);
        hinit_x = 1'b1;
        stepCen();
        hinit_x = 1'b0;
        checks++;
        if ({draw, done, obj_addr} !== 10'd0) begin
            errors++; $display("[TB] FAIL restart_drop: got %h expected 0", {draw, done, obj_addr});
        end
        busy = 1'b0;
        waitDraw(20, s, seen);
        checks++;
        if (!seen || s != 6 || code !== 9'h105) begin
            errors++; $display("[TB] FAIL restart_idx0: got s=%0d code=%h expected 6 105", s, code);
        end
        runToDone(300, d, s2, fin);
        applyStimulus(8'h45, 1'b0);
        stepCen();
        stepCen();
        checks++;
        if (obj_addr !== 8'h02) begin
            errors++; $display("[TB] FAIL midfetch_addr: got %h expected 02", obj_addr);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({obj_addr, draw, done, ovf, xpos, ysub, pal, code, hflip, vflip} !== 43'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h expected 0",
                     {obj_addr, draw, done, ovf, xpos, ysub, pal, code, hflip, vflip});
        end
        #20;
        rst = 1'b0;
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_no_hits();
        test_single_hit();
        test_wrap();
        test_busy_hold();
        test_overflow();
        test_flip();
        test_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
